// File: rtl/quant_pkg.sv
// Shared types and command-word layout for the quantiser gain coefficient loader.
package quant_pkg;

    localparam int unsigned CMD_TOGGLE_BIT = 31;
    localparam int unsigned CMD_FILL_BIT   = 30;

    // Fixed container widths; instances use the low ADDR_W / COEF_W bits.
    localparam int unsigned CMD_START_W = 16;
    localparam int unsigned CMD_COEF_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STABLE,
        ST_WAIT_SYNC,
        ST_WRITE,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [CMD_START_W-1:0] start;
        logic                   fill;
        logic [CMD_COEF_W-1:0]  coef;
    } cmd_t;

endpackage

// File: rtl/quant_cmd_qualifier.sv
// Detects a toggle of the command word, requires it to hold steady for STABLE_CYC
// cycles, then emits a one-cycle cmd_valid with the captured command.
module quant_cmd_qualifier
    import quant_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned COEF_W     = 18,
    parameter int unsigned STABLE_CYC = 3
) (
    input  logic        user_clk,
    input  logic        user_rst,
    input  logic        i_arm,
    input  logic [31:0] addr_reg,
    input  logic [31:0] data_reg,
    output logic        o_cmd_valid,
    output cmd_t        o_cmd
);

    localparam logic [3:0] STAB_LAST = 4'(STABLE_CYC - 1);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_cmp, w_cmp_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        r_last_toggle, w_toggle_nxt;
    logic        r_primed;
    logic        w_unused_data;

    assign w_unused_data = ^data_reg[31:COEF_W];

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_state       <= ST_IDLE;
            r_cmp         <= '0;
            r_cnt         <= '0;
            r_last_toggle <= 1'b0;
            r_primed      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cmp         <= w_cmp_nxt;
            r_cnt         <= w_cnt_nxt;
            r_last_toggle <= w_toggle_nxt;
            r_primed      <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cmp_nxt    = r_cmp;
        w_cnt_nxt    = r_cnt;
        w_toggle_nxt = r_last_toggle;
        o_cmd_valid  = 1'b0;
        o_cmd.start  = CMD_START_W'(r_cmp[ADDR_W-1:0]);
        o_cmd.fill   = r_cmp[CMD_FILL_BIT];
        o_cmd.coef   = CMD_COEF_W'(data_reg[COEF_W-1:0]);

        case (r_state)
            ST_IDLE: begin
                // First cycle after reset only adopts the current toggle, so a stale word never fires.
                if (!r_primed) begin
                    w_toggle_nxt = addr_reg[CMD_TOGGLE_BIT];
                end else if (i_arm && (addr_reg[CMD_TOGGLE_BIT] != r_last_toggle)) begin
                    w_cmp_nxt   = addr_reg;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_STABLE;
                end
            end
            ST_STABLE: begin
                if (addr_reg[CMD_TOGGLE_BIT] == r_last_toggle) begin
                    w_state_nxt = ST_IDLE;
                end else if (addr_reg != r_cmp) begin
                    w_cmp_nxt = addr_reg;
                    w_cnt_nxt = '0;
                end else if (r_cnt == STAB_LAST) begin
                    o_cmd_valid  = 1'b1;
                    w_toggle_nxt = r_cmp[CMD_TOGGLE_BIT];
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/quant_coeff_loader.sv
// Quantiser gain BRAM loader: qualified software commands become single writes or
// range fills to the top of the BRAM, optionally released by the spectrum sync.
module quant_coeff_loader
    import quant_pkg::*;
#(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned COEF_W       = 18,
    parameter int unsigned STABLE_CYC   = 3,
    parameter bit          GATE_ON_SYNC = 1'b1
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic [31:0]       addr_reg,
    input  logic [31:0]       data_reg,
    input  logic              sync_in,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [COEF_W-1:0] bram_din,
    output logic              busy,
    output logic [15:0]       cmd_count,
    output logic [31:0]       status
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    logic        w_cmd_valid;
    cmd_t        w_cmd;
    logic        w_cmd_load;
    logic        w_unused_cmd;

    state_t            r_state, w_state_nxt;
    logic              r_we, w_we_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [COEF_W-1:0] r_din, w_din_nxt;
    logic              r_busy, w_busy_nxt;
    logic [15:0]       r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0] r_start;
    logic              r_fill;
    logic [COEF_W-1:0] r_coef;

    quant_cmd_qualifier #(
        .ADDR_W    (ADDR_W),
        .COEF_W    (COEF_W),
        .STABLE_CYC(STABLE_CYC)
    ) u_qual (
        .user_clk   (user_clk),
        .user_rst   (user_rst),
        .i_arm      (r_state == ST_IDLE),
        .addr_reg   (addr_reg),
        .data_reg   (data_reg),
        .o_cmd_valid(w_cmd_valid),
        .o_cmd      (w_cmd)
    );

    assign w_unused_cmd = ^{w_cmd.start[CMD_START_W-1:ADDR_W], w_cmd.coef[CMD_COEF_W-1:COEF_W]};

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_start <= '0;
            r_fill  <= 1'b0;
            r_coef  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_din   <= w_din_nxt;
            r_busy  <= w_busy_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_cmd_load) begin
                r_start <= w_cmd.start[ADDR_W-1:0];
                r_fill  <= w_cmd.fill;
                r_coef  <= w_cmd.coef[COEF_W-1:0];
            end
        end
    end

    // Output registers are loaded from next-state values so the first write lands the cycle after capture.
    always_comb begin
        w_state_nxt = r_state;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = r_addr;
        w_din_nxt   = r_din;
        w_busy_nxt  = r_busy;
        w_cnt_nxt   = r_cnt;
        w_cmd_load  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_cmd_valid) begin
                    w_cmd_load = 1'b1;
                    w_busy_nxt = 1'b1;
                    if (GATE_ON_SYNC) begin
                        w_state_nxt = ST_WAIT_SYNC;
                    end else begin
                        w_state_nxt = ST_WRITE;
                        w_we_nxt    = 1'b1;
                        w_addr_nxt  = w_cmd.start[ADDR_W-1:0];
                        w_din_nxt   = w_cmd.coef[COEF_W-1:0];
                    end
                end
            end
            ST_WAIT_SYNC: begin
                if (sync_in) begin
                    w_state_nxt = ST_WRITE;
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = r_start;
                    w_din_nxt   = r_coef;
                end
            end
            ST_WRITE: begin
                if (r_fill && (r_addr != ADDR_MAX)) begin
                    w_we_nxt   = 1'b1;
                    w_addr_nxt = r_addr + 1'b1;
                end else begin
                    w_state_nxt = ST_DONE;
                    w_busy_nxt  = 1'b0;
                    w_cnt_nxt   = r_cnt + 16'd1;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bram_we   = r_we;
    assign bram_addr = r_addr;
    assign bram_din  = r_din;
    assign busy      = r_busy;
    assign cmd_count = r_cnt;
    assign status    = {r_busy, 15'h0000, r_cnt};

endmodule

// File: doc/quant_coeff_loader.md
Name: quant_coeff_loader

Overview:
- Sits in the user_clk domain directly downstream of the quant address/data software registers (opb_register_ppc2simulink outputs).
- Watches the 32-bit address command word for a new command, qualifies it as stable, and optionally aligns it to the spectrum sync pulse.
- Writes the coefficient word into the quantiser gain BRAM, either as a single write or as a fill of a contiguous address range.
- Reports busy and a command counter back to software through a simulink2ppc register.

Parameters:
- ADDR_W, 10, gain BRAM address width (channels per quantiser = 2**ADDR_W)
- COEF_W, 18, coefficient width; taken from data_reg[COEF_W-1:0]
- STABLE_CYC, 3, consecutive cycles the command word must stay unchanged before it is accepted (range 1..15)
- GATE_ON_SYNC, 1, 1 = hold each accepted command until sync_in is high; 0 = execute immediately

Ports:
- user_clk  in  1  block clock
- user_rst  in  1  synchronous, active-high reset
- addr_reg  in  32  command word: [ADDR_W-1:0] = start address; [30] = fill mode; [31] = toggle bit, software inverts it to issue a new command
- data_reg  in  32  coefficient value; software writes it before toggling addr_reg[31]
- sync_in  in  1  one-cycle spectrum-start pulse
- bram_we  out  1  gain BRAM write enable
- bram_addr  out  ADDR_W  gain BRAM address
- bram_din  out  COEF_W  gain BRAM data
- busy  out  1  high from command acceptance until the last write completes
- cmd_count  out  16  number of completed commands; wraps at 16 bits
- status  out  32  {busy, 15'b0, cmd_count}; intended for a simulink2ppc register

Behaviour:
- Reset:
  - All outputs are 0.
  - last_toggle is loaded from addr_reg[31] on the first post-reset cycle, so a stale register value never fires a command.
  - State = IDLE.
- IDLE:
  - If addr_reg[31] != last_toggle, load cmp_word = addr_reg, clear stab_cnt, go to STABLE.
- STABLE:
  - If addr_reg == cmp_word, increment stab_cnt; otherwise reload cmp_word and clear stab_cnt.
  - When stab_cnt reaches STABLE_CYC-1 with the word still equal, capture the command:
    - start = cmp_word[ADDR_W-1:0]
    - fill = cmp_word[30]
    - coef = data_reg[COEF_W-1:0], sampled in the same cycle
    - last_toggle = cmp_word[31]
    - busy = 1
    - next state = WAIT_SYNC if GATE_ON_SYNC, else WRITE
  - If the toggle reverts to last_toggle while in STABLE, return to IDLE with no write.
- WAIT_SYNC:
  - Stay until sync_in = 1, then go to WRITE on the next cycle.
  - A sync_in that arrives in the same cycle the command is captured does not count; only a later sync_in releases it.
- WRITE:
  - Every cycle: bram_we = 1, bram_din = coef, bram_addr = current address.
  - Single mode: exactly one write at start, then DONE.
  - Fill mode: one write per cycle from start up to 2**ADDR_W-1 inclusive, then DONE. The address never wraps to 0.
  - start = max address in fill mode gives exactly one write.
- DONE:
  - Exactly one cycle: bram_we = 0, busy = 0, cmd_count increments (wrapping 0xFFFF -> 0x0000), then IDLE.
- Latency, single mode with GATE_ON_SYNC = 0: from the first cycle the new toggle is visible to bram_we high is STABLE_CYC + 1 cycles.
- Toggle changes while busy:
  - They are not lost. IDLE compares against last_toggle, so a toggle flip during WAIT_SYNC/WRITE is picked up after DONE.
  - A double flip that returns to the same value is a no-op.
- Registered outputs: bram_* are registered. BRAM write latency is the BRAM's own and is outside this block.
- user_rst asserted mid-fill: the write stops on the next edge, bram_we = 0, cmd_count = 0, and the partially filled range stays as written.

Decomposition:
- Shared package quant_pkg:
  - state enum (IDLE, STABLE, WAIT_SYNC, WRITE, DONE)
  - command bit positions CMD_TOGGLE_BIT = 31, CMD_FILL_BIT = 30
  - a cmd_t record {start, fill, coef}
- Natural sub-module: quant_cmd_qualifier
  - Contains the toggle-detect plus stability counter.
  - Outputs a one-cycle cmd_valid with the captured cmd_t.
  - The top level holds the sequencer FSM, address counter and cmd_count.

Test Plan:
- Single write: reset, GATE_ON_SYNC = 0, data_reg = 0x00001234, addr_reg = 0x80000005 -> after 4 cycles exactly one bram_we with addr 5 and din 0x01234; cmd_count = 1; busy high for exactly the STABLE-to-WRITE span.
- Fill: ADDR_W = 10, addr_reg = 0x400003FC with toggle flipped to 0, data_reg = 0x7 -> 4 consecutive writes at 0x3FC..0x3FF, no write at 0x000, cmd_count increments by 1.
- Sync gating: GATE_ON_SYNC = 1, issue command, pulse sync_in 20 cycles later -> no bram_we before the sync; a single write in the cycle after the sync; a sync coincident with capture is ignored.
- Glitch rejection: change addr_reg[3:0] every cycle for 5 cycles after the toggle flip, then hold -> exactly one write using the final held address; toggle flip and revert within 2 cycles -> no write.
- Back-to-back: flip the toggle again during a 1024-word fill -> the second command executes after DONE; cmd_count = 2; no overlapping bram_we runs.
- Reset: assert user_rst mid-fill -> bram_we = 0 and busy = 0 on the next edge; cmd_count = 0; the stale toggle does not re-fire after reset release.
